store_monitor: RTL and testbench
================================

Name: store_monitor

Overview:
- Observes the data-memory store bus (MemWrite, DataAddr, WriteData) of Single_Cycle_Top and the pipelined core.
- Logs every store into a small first-word-fall-through FIFO for draining.
- Detects the test-completion store to a fixed "tohost" address, and raises pass/fail/timeout status.
- Sits between the core top and the bench, replacing ad-hoc store checks in testbenches.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TOHOST_ADDR, 32'd100, store address that ends the test.
- PASS_VALUE, 32'd25, data value at TOHOST_ADDR that means pass.
- TIMEOUT, 200, RUN cycles before a timeout is declared; must be below 2^16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemWrite  in  1  store strobe from the core.
- DataAddr  in  32  store byte address.
- WriteData  in  32  store data.
- pop  in  1  consume the FIFO head.
- log_valid  out  1  FIFO not empty.
- log_addr  out  32  head entry address.
- log_data  out  32  head entry data.
- log_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky; a store was dropped because the FIFO was full.
- done  out  1  state is not RUN.
- pass  out  1  state is PASS.
- fail  out  1  state is FAIL.
- timeout  out  1  state is TIMEOUT.
- cycle_count  out  16  RUN cycles elapsed.

Behaviour:
- Reset (rst=1 at an edge):
  - state=RUN, FIFO empty, log_count=0, log_valid=0.
  - overflow=0, cycle_count=0.
  - done, pass, fail and timeout all 0.
  - log_addr and log_data read 0 while the FIFO is empty.
- Reset mid-run discards all entries and status in that same edge.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until rst.
- RUN transitions, evaluated at each edge with MemWrite=1:
  - DataAddr==TOHOST_ADDR and WriteData==PASS_VALUE -> PASS.
  - DataAddr==TOHOST_ADDR and any other data -> FAIL.
- Timeout:
  - In RUN, cycle_count increments every edge.
  - When cycle_count==TIMEOUT-1 at an edge with no tohost store -> TIMEOUT.
  - A tohost store at that same edge wins (goes to PASS or FAIL).
  - cycle_count freezes once the state leaves RUN.
- Status outputs are registered. They assert one cycle after the edge that samples the deciding store; the latency is 1.
- Logging:
  - Every MemWrite=1 edge while in RUN pushes {DataAddr, WriteData}, including the tohost store itself.
  - Stores are not logged in terminal states.
- FIFO:
  - First-word fall-through: log_addr and log_data show the head combinationally whenever log_valid=1.
  - pop with log_valid=1 removes the head at the edge. pop while empty is ignored, with no underflow.
  - Push while full and no pop: the entry is dropped, overflow is set (sticky), and contents are unchanged.
  - Push and pop in the same edge while full: both occur and the count stays at DEPTH.
  - Push and pop in the same edge while empty: the push is kept, so the count goes to 1.
  - Pointers wrap modulo DEPTH.
  - log_count updates by +1, -1 or 0 per edge.
- Popping is allowed in any state, so the log can be drained after done.
- MemWrite equal to X is treated as 0. No other interface assumptions are made.

Decomposition:
- Shared package riscv_tb_pkg holds:
  - the state enum {RUN, PASS, FAIL, TIMEOUT} as a 2-bit encoding (0..3);
  - default TOHOST_ADDR and PASS_VALUE constants.
- One sub-module, sync_fifo:
  - parameters WIDTH=64 and DEPTH;
  - ports clk, rst, push, pop, din, dout, valid, count, full;
  - first-word fall-through.
- store_monitor holds the FSM, the cycle counter and the overflow flag.

Test Plan:
- Reset, then 3 stores (addr 4/data 7, addr 8/data 9, addr 12/data 11) -> log_count=3; popping returns them in order; log_valid drops after the 3rd pop.
- Store addr 100/data 25 -> pass=1 and done=1 the next cycle. A later store to addr 0 is not logged and the log holds the tohost entry last.
- Store addr 100/data 24 -> fail=1, pass=0. rst for 1 cycle -> all status 0 and log_count=0.
- No stores for 200 cycles -> timeout=1, cycle_count=199 frozen. Also: a tohost store with data 25 exactly at cycle 199 -> pass=1, timeout=0.
- 9 stores with no pop (DEPTH=8) -> log_count=8, overflow=1, and the head is still the first store. Push+pop in the same cycle while full -> count stays 8.
- pop while empty -> count stays 0. Push+pop in the same cycle while empty -> count=1 with the new entry at the head.

Source files
------------

// File: rtl/riscv_tb_pkg.sv
// rtl/riscv_tb_pkg.sv - shared monitor state encoding and tohost defaults
package riscv_tb_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PASS    = 2'd1,
      FAIL    = 2'd2,
      TIMEOUT = 2'd3
   } monState_t;

   localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'd100;
   localparam logic [31:0] DEFAULT_PASS_VALUE  = 32'd25;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             doPush;
   logic             doPop;

   assign valid  = (count != '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign doPop  = pop && valid;
   // A full FIFO still accepts a push when the head leaves in the same edge.
   assign doPush = push && (!full || doPop);
   assign dout   = valid ? mem[rdPtr] : '0;

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - store bus logger with tohost pass/fail/timeout detection
module store_monitor #(
   parameter int          DEPTH       = 8,
   parameter logic [31:0] TOHOST_ADDR = riscv_tb_pkg::DEFAULT_TOHOST_ADDR,
   parameter logic [31:0] PASS_VALUE  = riscv_tb_pkg::DEFAULT_PASS_VALUE,
   parameter int          TIMEOUT     = 200
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   MemWrite,
   input  logic [31:0]            DataAddr,
   input  logic [31:0]            WriteData,
   input  logic                   pop,
   output logic                   log_valid,
   output logic [31:0]            log_addr,
   output logic [31:0]            log_data,
   output logic [$clog2(DEPTH):0] log_count,
   output logic                   overflow,
   output logic                   done,
   output logic                   pass,
   output logic                   fail,
   output logic                   timeout,
   output logic [15:0]            cycle_count
);

   import riscv_tb_pkg::*;

   monState_t   stateQ;
   monState_t   stateD;
   logic        storeEn;
   logic        tohostHit;
   logic        logPush;
   logic        fifoFull;
   logic [63:0] fifoDout;

   // The TIMEOUT parameter hides the enum literal, so the state is named by scope.
   always_comb begin
      stateD    = stateQ;
      storeEn   = (MemWrite == 1'b1);
      tohostHit = storeEn && (DataAddr == TOHOST_ADDR);
      logPush   = 1'b0;
      if (stateQ == RUN) begin
         logPush = storeEn;
         if (tohostHit) begin
            stateD = (WriteData == PASS_VALUE) ? PASS : FAIL;
         end else if (cycle_count == 16'(TIMEOUT - 1)) begin
            stateD = riscv_tb_pkg::TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ      <= RUN;
         cycle_count <= '0;
         overflow    <= 1'b0;
      end else begin
         stateQ <= stateD;
         // Count stops on the deciding edge so it reports where the run ended.
         if (stateQ == RUN && stateD == RUN) begin
            cycle_count <= cycle_count + 16'd1;
         end
         if (logPush && fifoFull && !(pop && log_valid)) begin
            overflow <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH(64),
      .DEPTH(DEPTH)
   ) logFifo (
      .clk  (clk),
      .rst  (rst),
      .push (logPush),
      .pop  (pop),
      .din  ({DataAddr, WriteData}),
      .dout (fifoDout),
      .valid(log_valid),
      .count(log_count),
      .full (fifoFull)
   );

   assign log_addr = fifoDout[63:32];
   assign log_data = fifoDout[31:0];
   assign done     = (stateQ != RUN);
   assign pass     = (stateQ == PASS);
   assign fail     = (stateQ == FAIL);
   assign timeout  = (stateQ == riscv_tb_pkg::TIMEOUT);

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - self-checking bench for store_monitor
module tb_store_monitor;

   logic        clk;
   logic        rst;
   logic        MemWrite;
   logic [31:0] DataAddr;
   logic [31:0] WriteData;
   logic        pop;
   logic        log_valid;
   logic [31:0] log_addr;
   logic [31:0] log_data;
   logic [3:0]  log_count;
   logic        overflow;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic [15:0] cycle_count;

   int checks = 0;
   int errors = 0;

   store_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .MemWrite   (MemWrite),
      .DataAddr   (DataAddr),
      .WriteData  (WriteData),
      .pop        (pop),
      .log_valid  (log_valid),
      .log_addr   (log_addr),
      .log_data   (log_data),
      .log_count  (log_count),
      .overflow   (overflow),
      .done       (done),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .cycle_count(cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: status as 0=run 1=pass 2=fail 3=timeout, log as a queue.
   typedef struct {
      int a;
      int d;
   } entry_t;

   entry_t mq[$];
   int     mState;
   int     mCyc;
   bit     mOvf;

   typedef struct {
      bit r;
      bit mw;
      int a;
      int d;
      bit p;
      int eCnt;
      bit eValid;
      int eAddr;
      int eData;
      bit ePass;
      bit eFail;
      bit eDone;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelStep(input bit r, input bit mw, input int a, input int d, input bit p);
      bit     popOk;
      bit     pushReq;
      int     sizeBefore;
      entry_t e;
      if (r) begin
         mq.delete();
         mState = 0;
         mCyc   = 0;
         mOvf   = 1'b0;
      end else begin
         sizeBefore = mq.size();
         popOk      = p && (sizeBefore > 0);
         pushReq    = mw && (mState == 0);
         if (pushReq && sizeBefore == 8 && !popOk) mOvf = 1'b1;
         if (popOk) void'(mq.pop_front());
         if (pushReq && (sizeBefore < 8 || popOk)) begin
            e.a = a;
            e.d = d;
            mq.push_back(e);
         end
         if (mState == 0) begin
            if (mw && a == 100) mState = (d == 25) ? 1 : 2;
            else if (mCyc == 199) mState = 3;
            else mCyc++;
         end
      end
   endtask

   task automatic compareModel();
      check("count", 32'(log_count), 32'(mq.size()));
      check("valid", 32'(log_valid), 32'(mq.size() > 0));
      check("head_addr", log_addr, (mq.size() > 0) ? 32'(mq[0].a) : 32'd0);
      check("head_data", log_data, (mq.size() > 0) ? 32'(mq[0].d) : 32'd0);
      check("overflow", 32'(overflow), 32'(mOvf));
      check("done", 32'(done), 32'(mState != 0));
      check("pass", 32'(pass), 32'(mState == 1));
      check("fail", 32'(fail), 32'(mState == 2));
      check("timeout", 32'(timeout), 32'(mState == 3));
      check("cycle_count", 32'(cycle_count), 32'(mCyc));
   endtask

   task automatic cycle(input bit r, input bit mw, input int a, input int d, input bit p);
      rst       = r;
      MemWrite  = mw;
      DataAddr  = 32'(a);
      WriteData = 32'(d);
      pop       = p;
      modelStep(r, mw, a, d, p);
      @(posedge clk);
      #1;
      compareModel();
   endtask

   initial begin
      bit rr, mw, pp;
      int aa, dd;

      rst = 1'b1; MemWrite = 1'b0; DataAddr = '0; WriteData = '0; pop = 1'b0;
      mState = 0; mCyc = 0; mOvf = 1'b0;

      //            r  mw  addr data p  cnt val  hAddr hData pass fail done
      vecs[0]  = '{1, 0,   0,   0, 0,  0, 0,    0,    0,  0, 0, 0};
      vecs[1]  = '{0, 1,   4,   7, 0,  1, 1,    4,    7,  0, 0, 0};
      vecs[2]  = '{0, 1,   8,   9, 0,  2, 1,    4,    7,  0, 0, 0};
      vecs[3]  = '{0, 1,  12,  11, 0,  3, 1,    4,    7,  0, 0, 0};
      vecs[4]  = '{0, 0,   0,   0, 1,  2, 1,    8,    9,  0, 0, 0};
      vecs[5]  = '{0, 0,   0,   0, 1,  1, 1,   12,   11,  0, 0, 0};
      vecs[6]  = '{0, 0,   0,   0, 1,  0, 0,    0,    0,  0, 0, 0};
      vecs[7]  = '{0, 0,   0,   0, 1,  0, 0,    0,    0,  0, 0, 0};
      vecs[8]  = '{0, 1,  16,   5, 1,  1, 1,   16,    5,  0, 0, 0};
      vecs[9]  = '{0, 0,   0,   0, 1,  0, 0,    0,    0,  0, 0, 0};
      vecs[10] = '{0, 1, 100,  25, 0,  1, 1,  100,   25,  1, 0, 1};
      vecs[11] = '{0, 1,   0,   3, 0,  1, 1,  100,   25,  1, 0, 1};
      vecs[12] = '{1, 0,   0,   0, 0,  0, 0,    0,    0,  0, 0, 0};
      vecs[13] = '{0, 1, 100,  24, 0,  1, 1,  100,   24,  0, 1, 1};
      vecs[14] = '{1, 0,   0,   0, 0,  0, 0,    0,    0,  0, 0, 0};

      for (int i = 0; i < 15; i++) begin
         cycle(vecs[i].r, vecs[i].mw, vecs[i].a, vecs[i].d, vecs[i].p);
         check($sformatf("vec%0d_count", i), 32'(log_count), 32'(vecs[i].eCnt));
         check($sformatf("vec%0d_valid", i), 32'(log_valid), 32'(vecs[i].eValid));
         check($sformatf("vec%0d_addr", i), log_addr, 32'(vecs[i].eAddr));
         check($sformatf("vec%0d_data", i), log_data, 32'(vecs[i].eData));
         check($sformatf("vec%0d_pass", i), 32'(pass), 32'(vecs[i].ePass));
         check($sformatf("vec%0d_fail", i), 32'(fail), 32'(vecs[i].eFail));
         check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].eDone));
      end

      // Idle run to timeout, then confirm the counter stays frozen.
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 200; i++) cycle(0, 0, 0, 0, 0);
      check("to_timeout", 32'(timeout), 32'd1);
      check("to_count", 32'(cycle_count), 32'd199);
      for (int i = 0; i < 5; i++) cycle(0, 1, 40, 1, 0);
      check("to_frozen", 32'(cycle_count), 32'd199);
      check("to_nolog", 32'(log_count), 32'd0);

      // Tohost store on the timeout edge wins.
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 199; i++) cycle(0, 0, 0, 0, 0);
      check("edge_count", 32'(cycle_count), 32'd199);
      cycle(0, 1, 100, 25, 0);
      check("edge_pass", 32'(pass), 32'd1);
      check("edge_timeout", 32'(timeout), 32'd0);

      // Overflow: nine stores into eight entries, then push+pop while full.
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) cycle(0, 1, 32'h200 + 4 * i, i + 1, 0);
      check("ovf_count", 32'(log_count), 32'd8);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_head", log_addr, 32'h200);
      cycle(0, 1, 32'h300, 77, 1);
      check("full_pp_count", 32'(log_count), 32'd8);
      check("full_pp_head", log_addr, 32'h204);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1);
      check("drained_count", 32'(log_count), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Randomised traffic against the model.
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         rr = ($urandom_range(0, 199) == 0);
         mw = ($urandom_range(0, 1) == 1);
         aa = ($urandom_range(0, 39) == 0) ? 100 : int'($urandom_range(0, 63)) * 4;
         dd = ($urandom_range(0, 2) == 0) ? 25 : int'($urandom);
         pp = ($urandom_range(0, 9) < 4);
         cycle(rr, mw, aa, dd, pp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
